// File: rtl/fxu_pkg.sv
// Shared definitions for the fixed-point execution unit: opcode encoding and result flags.
package fxu_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'd3;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'd4;
    localparam logic [OPC_W-1:0] OP_MOVL = 4'd5;
    localparam logic [OPC_W-1:0] OP_MOVH = 4'd6;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'd7;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'd8;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'd9;
    localparam logic [OPC_W-1:0] OP_SRA  = 4'd10;
    localparam logic [OPC_W-1:0] OP_SLT  = 4'd11;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic illegal;
    } fxu_flags_t;

endpackage

// File: rtl/fxu_alu.sv
// Combinational fixed-point ALU: opcode and operands in, result value and flags out.
module fxu_alu
    import fxu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 8
) (
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [DATA_W-1:0] i_va,
    input  logic [DATA_W-1:0] i_vb,
    input  logic [IMM_W-1:0]  i_imm,
    output logic [DATA_W-1:0] o_value_c,
    output logic              o_carry_c,
    output logic              o_overflow_c,
    output logic              o_zero_c,
    output logic              o_illegal_c
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [SH_W-1:0]   w_shamt;
    logic              w_sign_a;
    logic              w_sign_b;

    // Extra top bit carries the add carry-out / subtract borrow.
    assign w_sum    = {1'b0, i_va} + {1'b0, i_vb};
    assign w_diff   = {1'b0, i_va} - {1'b0, i_vb};
    assign w_shamt  = i_vb[SH_W-1:0];
    assign w_sign_a = i_va[DATA_W-1];
    assign w_sign_b = i_vb[DATA_W-1];

    always_comb begin
        o_value_c    = '0;
        o_carry_c    = 1'b0;
        o_overflow_c = 1'b0;
        o_illegal_c  = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                o_value_c    = w_sum[DATA_W-1:0];
                o_carry_c    = w_sum[DATA_W];
                o_overflow_c = (w_sign_a == w_sign_b) && (w_sum[DATA_W-1] != w_sign_a);
            end
            OP_SUB: begin
                o_value_c    = w_diff[DATA_W-1:0];
                o_carry_c    = w_diff[DATA_W];
                o_overflow_c = (w_sign_a != w_sign_b) && (w_diff[DATA_W-1] != w_sign_a);
            end
            OP_AND:  o_value_c = i_va & i_vb;
            OP_OR:   o_value_c = i_va | i_vb;
            OP_MOV:  o_value_c = i_va;
            OP_MOVL: o_value_c = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
            OP_MOVH: o_value_c = {i_imm, i_va[DATA_W-IMM_W-1:0]};
            OP_XOR:  o_value_c = i_va ^ i_vb;
            OP_SHL:  o_value_c = i_va << w_shamt;
            OP_SHR:  o_value_c = i_va >> w_shamt;
            OP_SRA:  o_value_c = $signed(i_va) >>> w_shamt;
            OP_SLT:  o_value_c = DATA_W'($signed(i_va) < $signed(i_vb));
            default: o_illegal_c = 1'b1;
        endcase
    end

    assign o_zero_c = (o_value_c == '0);

endmodule

// File: rtl/fxu_pipe.sv
// Two-stage fixed-point execution unit: operand register, ALU, result register,
// with valid/ready backpressure on both sides and a single-cycle flush.
module fxu_pipe
    import fxu_pkg::fxu_flags_t;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned IMM_W     = 8,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned OPC_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPC_W-1:0]     in_opcode,
    input  logic [ROB_IDX_W-1:0] in_index,
    input  logic [DATA_W-1:0]    in_va,
    input  logic [DATA_W-1:0]    in_vb,
    input  logic [IMM_W-1:0]     in_i,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROB_IDX_W-1:0] out_rob_index,
    output logic [DATA_W-1:0]    out_return_value,
    output logic                 out_carry,
    output logic                 out_overflow,
    output logic                 out_zero,
    output logic                 out_illegal
);

    logic                 r_s1_valid;
    logic [OPC_W-1:0]     r_s1_opcode;
    logic [ROB_IDX_W-1:0] r_s1_index;
    logic [DATA_W-1:0]    r_s1_va;
    logic [DATA_W-1:0]    r_s1_vb;
    logic [IMM_W-1:0]     r_s1_imm;

    logic                 r_s2_valid;
    logic [ROB_IDX_W-1:0] r_s2_index;
    logic [DATA_W-1:0]    r_s2_value;
    fxu_flags_t           r_s2_flags;

    logic                 w_s2_free;
    logic                 w_s1_adv;
    logic                 w_in_fire;
    logic [DATA_W-1:0]    w_alu_value;
    fxu_flags_t           w_alu_flags;

    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_in_fire = in_valid && in_ready;

    fxu_alu #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_alu (
        .i_opcode     (r_s1_opcode),
        .i_va         (r_s1_va),
        .i_vb         (r_s1_vb),
        .i_imm        (r_s1_imm),
        .o_value_c    (w_alu_value),
        .o_carry_c    (w_alu_flags.carry),
        .o_overflow_c (w_alu_flags.overflow),
        .o_zero_c     (w_alu_flags.zero),
        .o_illegal_c  (w_alu_flags.illegal)
    );

    // Flush only clears valids; stale payload is harmless once invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_opcode <= '0;
            r_s1_index  <= '0;
            r_s1_va     <= '0;
            r_s1_vb     <= '0;
            r_s1_imm    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_index  <= '0;
            r_s2_value  <= '0;
            r_s2_flags  <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid  <= 1'b1;
                r_s1_opcode <= in_opcode;
                r_s1_index  <= in_index;
                r_s1_va     <= in_va;
                r_s1_vb     <= in_vb;
                r_s1_imm    <= in_i;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_index <= r_s1_index;
                r_s2_value <= w_alu_value;
                r_s2_flags <= w_alu_flags;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid        = r_s2_valid;
    assign out_rob_index    = r_s2_index;
    assign out_return_value = r_s2_value;
    assign out_carry        = r_s2_flags.carry;
    assign out_overflow     = r_s2_flags.overflow;
    assign out_zero         = r_s2_flags.zero;
    assign out_illegal      = r_s2_flags.illegal;

endmodule

// File: tb/tb_fxu_pipe.sv
// Self-checking bench for fxu_pipe: directed vector table, pipeline corner sequences
// and a random stream, all checked through an in-order result scoreboard.
module tb_fxu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [3:0]  in_index;
    logic [15:0] in_va;
    logic [15:0] in_vb;
    logic [7:0]  in_i;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_rob_index;
    logic [15:0] out_return_value;
    logic        out_carry;
    logic        out_overflow;
    logic        out_zero;
    logic        out_illegal;

    fxu_pipe #(
        .DATA_W    (16),
        .IMM_W     (8),
        .ROB_IDX_W (4),
        .OPC_W     (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_opcode        (in_opcode),
        .in_index         (in_index),
        .in_va            (in_va),
        .in_vb            (in_vb),
        .in_i             (in_i),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_rob_index    (out_rob_index),
        .out_return_value (out_return_value),
        .out_carry        (out_carry),
        .out_overflow     (out_overflow),
        .out_zero         (out_zero),
        .out_illegal      (out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // flg = {carry, overflow, zero, illegal}
    typedef struct {
        logic [3:0]  idx;
        logic [15:0] val;
        logic [3:0]  flg;
    } exp_t;

    typedef struct {
        logic [3:0]  opc;
        logic [15:0] va;
        logic [15:0] vb;
        logic [7:0]  imm;
        logic [15:0] val;
        logic [3:0]  flg;
    } vec_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] opc, input logic [15:0] va,
                                   input logic [15:0] vb, input logic [7:0] imm);
        exp_t e;
        int ua, ub, sa, sb_, r;
        logic [3:0] sh;
        logic c, v, ill;
        ua = int'(va);
        ub = int'(vb);
        sa = int'($signed(va));
        sb_ = int'($signed(vb));
        sh = vb[3:0];
        c = 1'b0; v = 1'b0; ill = 1'b0; r = 0;
        case (opc)
            4'd0: begin r = ua + ub; c = (r > 65535); v = (sa + sb_ > 32767) || (sa + sb_ < -32768); end
            4'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb_ > 32767) || (sa - sb_ < -32768); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua;
            4'd5: r = int'($signed(imm));
            4'd6: r = (int'(imm) * 256) + (ua % 256);
            4'd7: r = ua ^ ub;
            4'd8: r = ua << sh;
            4'd9: r = ua >> sh;
            4'd10: r = sa >>> sh;
            4'd11: r = (sa < sb_) ? 1 : 0;
            default: ill = 1'b1;
        endcase
        e.idx = '0;
        e.val = 16'(r);
        e.flg = {c, v, (e.val == 16'h0), ill};
        return e;
    endfunction

    task automatic drive(input logic [3:0] opc, input logic [3:0] idx, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] imm, input exp_t e);
        in_valid  = 1'b1;
        in_opcode = opc;
        in_index  = idx;
        in_va     = a;
        in_vb     = b;
        in_i      = imm;
        cur_exp   = e;
    endtask

    // One clock: check any consumed result, log any accepted issue, advance to next negedge.
    task automatic tick(output bit acc);
        exp_t e;
        #1;
        acc = 1'b0;
        if (rst_n && out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_out: got tag 0x%0h, expected no result", out_rob_index);
            end else begin
                e = sb.pop_front();
                chk("res_tag", 32'(out_rob_index), 32'(e.idx));
                chk("res_value", 32'(out_return_value), 32'(e.val));
                chk("res_flags", 32'({out_carry, out_overflow, out_zero, out_illegal}), 32'(e.flg));
            end
        end
        if (rst_n && !flush && in_valid && in_ready === 1'b1) begin
            acc = 1'b1;
            e = cur_exp;
            e.idx = in_index;
            sb.push_back(e);
        end
        if (!rst_n || flush) sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] opc, input logic [3:0] idx, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] imm, input exp_t e);
        bit acc;
        acc = 1'b0;
        drive(opc, idx, a, b, imm, e);
        for (int n = 0; n < 20 && !acc; n++) tick(acc);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: got no accept for tag 0x%0h, expected accept", idx);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() > 0; n++) tick(acc);
        tick(acc);
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    vec_t tbl[18];

    initial begin
        bit acc;
        exp_t e;
        logic [3:0]  hold_tag;
        logic [15:0] hold_val;
        logic [3:0]  tag;

        tbl[0]  = '{4'd0,  16'h7FFF, 16'h0001, 8'h00, 16'h8000, 4'b0100};
        tbl[1]  = '{4'd1,  16'h0003, 16'h0005, 8'h00, 16'hFFFE, 4'b1000};
        tbl[2]  = '{4'd1,  16'h0005, 16'h0005, 8'h00, 16'h0000, 4'b0010};
        tbl[3]  = '{4'd5,  16'h1234, 16'h0000, 8'h80, 16'hFF80, 4'b0000};
        tbl[4]  = '{4'd6,  16'hABCD, 16'h0000, 8'h12, 16'h12CD, 4'b0000};
        tbl[5]  = '{4'd10, 16'h8000, 16'h0004, 8'h00, 16'hF800, 4'b0000};
        tbl[6]  = '{4'd13, 16'h1111, 16'h2222, 8'h33, 16'h0000, 4'b0011};
        tbl[7]  = '{4'd0,  16'hFFFF, 16'h0001, 8'h00, 16'h0000, 4'b1010};
        tbl[8]  = '{4'd1,  16'h8000, 16'h0001, 8'h00, 16'h7FFF, 4'b0100};
        tbl[9]  = '{4'd2,  16'hF0F0, 16'h0FF0, 8'h00, 16'h00F0, 4'b0000};
        tbl[10] = '{4'd3,  16'h1200, 16'h0034, 8'h00, 16'h1234, 4'b0000};
        tbl[11] = '{4'd7,  16'hFFFF, 16'hFFFF, 8'h00, 16'h0000, 4'b0010};
        tbl[12] = '{4'd8,  16'h0001, 16'h0013, 8'h00, 16'h0008, 4'b0000};
        tbl[13] = '{4'd9,  16'h8000, 16'h000F, 8'h00, 16'h0001, 4'b0000};
        tbl[14] = '{4'd11, 16'hFFFF, 16'h0001, 8'h00, 16'h0001, 4'b0000};
        tbl[15] = '{4'd11, 16'h0001, 16'hFFFF, 8'h00, 16'h0000, 4'b0010};
        tbl[16] = '{4'd4,  16'h5A5A, 16'h0000, 8'h00, 16'h5A5A, 4'b0000};
        tbl[17] = '{4'd15, 16'h0000, 16'h0000, 8'hFF, 16'h0000, 4'b0011};

        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_index = '0;
        in_va = '0; in_vb = '0; in_i = '0; flush = 1'b0; out_ready = 1'b1;
        cur_exp = '{4'h0, 16'h0, 4'h0};
        @(negedge clk);
        tick(acc);
        tick(acc);
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", {12'h0, out_rob_index, out_return_value},
            32'd0);
        chk("rst_flags", 32'({out_carry, out_overflow, out_zero, out_illegal}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: accepted in cycle N, visible in cycle N+2.
        e = '{4'h0, 16'h8000, 4'b0100};
        drive(4'd0, 4'h5, 16'h7FFF, 16'h0001, 8'h00, e);
        tick(acc);
        chk("lat_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        chk("lat_n1_valid", 32'(out_valid), 32'd0);
        tick(acc);
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        drain();

        // Directed vectors back-to-back at full throughput.
        for (int i = 0; i < 18; i++) begin
            e = '{4'(i), tbl[i].val, tbl[i].flg};
            drive(tbl[i].opc, 4'(i), tbl[i].va, tbl[i].vb, tbl[i].imm, e);
            tick(acc);
            chk("tbl_accept", 32'(acc), 32'd1);
        end
        drain();

        // Backpressure: two ops fill both stages, third is refused, output held.
        out_ready = 1'b0;
        drive(4'd0, 4'h8, 16'h0010, 16'h0020, 8'h00, model(4'd0, 16'h0010, 16'h0020, 8'h00));
        tick(acc);
        chk("bp_acc0", 32'(acc), 32'd1);
        drive(4'd1, 4'h9, 16'h0100, 16'h0001, 8'h00, model(4'd1, 16'h0100, 16'h0001, 8'h00));
        tick(acc);
        chk("bp_acc1", 32'(acc), 32'd1);
        drive(4'd7, 4'hA, 16'hAAAA, 16'h5555, 8'h00, model(4'd7, 16'hAAAA, 16'h5555, 8'h00));
        #1;
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        hold_tag = out_rob_index;
        hold_val = out_return_value;
        tick(acc);
        chk("bp_refused", 32'(acc), 32'd0);
        tick(acc);
        tick(acc);
        chk("bp_hold_tag", 32'(out_rob_index), 32'(hold_tag));
        chk("bp_hold_val", 32'(out_return_value), 32'(hold_val));
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        issue(4'd7, 4'hA, 16'hAAAA, 16'h5555, 8'h00, model(4'd7, 16'hAAAA, 16'h5555, 8'h00));
        issue(4'd8, 4'hB, 16'h0003, 16'h0002, 8'h00, model(4'd8, 16'h0003, 16'h0002, 8'h00));
        drain();

        // Flush with both stages full and a new op presented.
        out_ready = 1'b0;
        issue(4'd0, 4'h1, 16'h0001, 16'h0001, 8'h00, model(4'd0, 16'h0001, 16'h0001, 8'h00));
        issue(4'd0, 4'h2, 16'h0002, 16'h0002, 8'h00, model(4'd0, 16'h0002, 16'h0002, 8'h00));
        drive(4'd4, 4'hE, 16'hDEAD, 16'h0000, 8'h00, model(4'd4, 16'hDEAD, 16'h0000, 8'h00));
        flush = 1'b1;
        tick(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) tick(acc);
        issue(4'd1, 4'h3, 16'h0005, 16'h0005, 8'h00, '{4'h0, 16'h0000, 4'b0010});
        drain();

        // Reset in the middle of a stream discards in-flight ops.
        issue(4'd3, 4'h6, 16'h00F0, 16'h000F, 8'h00, model(4'd3, 16'h00F0, 16'h000F, 8'h00));
        issue(4'd3, 4'h7, 16'hF000, 16'h0F00, 8'h00, model(4'd3, 16'hF000, 16'h0F00, 8'h00));
        rst_n = 1'b0;
        tick(acc);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_outputs", {12'h0, out_rob_index, out_return_value}, 32'd0);
        chk("mid_rst_flags", 32'({out_carry, out_overflow, out_zero, out_illegal}), 32'd0);
        rst_n = 1'b1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        for (int n = 0; n < 3; n++) tick(acc);

        // Random stream with random backpressure.
        tag = 4'h0;
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  o;
            logic [15:0] a, b;
            logic [7:0]  im;
            o  = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            im = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            drive(o, tag, a, b, im, model(o, a, b, im));
            in_valid = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) tag = tag + 4'h1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fxu_pipe.md
Name: fxu_pipe

Overview:
Parametrised fixed-point execution unit, the successor of the single-stage FXU. Takes issued ops (opcode, ROB index, decoded operands, immediate) from the reservation stations and computes the result. Returns result, flags and ROB index to the ROB/CDB arbiter through a two-stage valid/ready pipeline with full backpressure and pipeline flush. Widths and ROB depth are parameters; ALU ops extended with logic, shift and compare.

Parameters:
DATA_W, 16, operand/result width; must be > IMM_W
IMM_W, 8, immediate width
ROB_IDX_W, 4, ROB index width
OPC_W, 4, opcode width (fixed encoding below; 4 is the only legal value)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  issue request
in_ready  out  1  unit can accept this cycle
in_opcode  in  OPC_W  operation
in_index  in  ROB_IDX_W  ROB tag
in_va  in  DATA_W  operand A
in_vb  in  DATA_W  operand B
in_i  in  IMM_W  immediate
flush  in  1  kill all in-flight ops (mispredict/exception)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_rob_index  out  ROB_IDX_W  tag of result
out_return_value  out  DATA_W  result
out_carry  out  1  add: carry-out; sub: borrow (va < vb unsigned); else 0
out_overflow  out  1  signed overflow for add/sub; else 0
out_zero  out  1  result == 0
out_illegal  out  1  opcode 12..15; result forced 0

Behaviour:
- Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 mov (va), 5 movl (sign-extend in_i to DATA_W), 6 movh ({in_i, va[DATA_W-IMM_W-1:0]}), 7 xor, 8 shl, 9 shr logical, 10 sra arithmetic, 11 slt (signed va<vb -> 1 else 0), 12..15 illegal.
- Shift amount = vb[$clog2(DATA_W)-1:0]; upper vb bits ignored. Add/sub wrap modulo 2^DATA_W.
- Stage S1: operand register (captures opcode, index, va, vb, i on handshake). Stage S2: result register (value, flags, index). Compute is combinational between S1 and S2.
- Handshake: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready. Payload held stable while out_valid && !out_ready.
- s2_free = !s2_valid || out_ready; s1 advances when s1_valid && s2_free; in_ready = !s1_valid || s2_free (combinational, no dependency on in_valid).
- Latency: accepted in cycle N -> out_valid in cycle N+2 (no stall). Throughput 1 op/cycle with out_ready held high.
- Full: both stages valid and out_ready=0 -> in_ready=0; nothing lost or duplicated.
- flush: next cycle s1_valid=s2_valid=0; an input presented in the flush cycle is dropped regardless of in_ready; a result consumed in the flush cycle counts as delivered. flush has priority over all advances.
- Reset (rst_n=0 at posedge): s1_valid, s2_valid cleared; out_valid=0, out_rob_index=0, out_return_value=0, all flags 0; in_ready=1 the cycle after reset released. Reset mid-operation discards in-flight ops. Payload registers reset to 0.
- No X propagation: outputs defined whenever out_valid=1; out_valid never X after reset.

Decomposition:
- Shared package fxu_pkg: opcode localparams (OP_ADD..OP_SLT), OPC_W, flag struct typedef {carry, overflow, zero, illegal}.
- One sub-module natural: fxu_alu (pure combinational, DATA_W/IMM_W params, opcode+operands -> value+flags), reused by future FXU instances; fxu_pipe holds the two stages and handshake.

Test Plan:
- Reset then add va=0x7FFF vb=0x0001, out_ready=1 -> two cycles later out_valid=1, value 0x8000, overflow=1, carry=0, index echoed.
- sub va=0x0003 vb=0x0005 -> value 0xFFFE, carry(borrow)=1, zero=0; sub 5-5 -> 0x0000, zero=1.
- movl i=0x80 -> 0xFF80; movh i=0x12 va=0xABCD -> 0x12CD; sra va=0x8000 vb=0x0004 -> 0xF800; opcode 13 -> value 0, illegal=1.
- Back-to-back 4 ops, out_ready=0 from cycle 2 -> in_ready drops after 2 accepted, held output stable; release out_ready -> all 4 tags emerge in order, no loss/dup.
- flush asserted with both stages full plus in_valid=1 -> next cycle out_valid=0, dropped op never appears; new op issued after flush completes normally.
- Assert rst_n=0 mid-stream for one cycle -> out_valid=0 and all outputs 0 next cycle, in_ready=1 after release.
